// File: rtl/booth_mac_accum.sv
// Pipelined signed multiply-accumulate: operand register, radix-4 Booth multiplier,
// product register, wide wrapping accumulator with sticky per-group overflow.

module booth_mul #(
  parameter int W = 16
) (
  input  logic signed [W-1:0]   x,
  input  logic signed [W-1:0]   y,
  output logic signed [2*W-1:0] prod
);

  logic [W:0]             y_ext;
  logic [2:0]             trip;
  logic signed [2*W-1:0]  x_ext;
  logic signed [2*W-1:0]  pp;

  // Radix-4 recoding: each overlapping triplet of y selects 0, +-x or +-2x.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no latch can be inferred.
    prod  = '0;
    pp    = '0;
    trip  = '0;
    y_ext = {y, 1'b0};
    x_ext = {{W{x[W-1]}}, x};
    for (int i = 0; i < W / 2; i++) begin
      trip = y_ext[2*i +: 3];
      unique case (trip)
        3'b001, 3'b010: pp = x_ext;
        3'b011:         pp = x_ext <<< 1;
        3'b100:         pp = -(x_ext <<< 1);
        3'b101, 3'b110: pp = -x_ext;
        default:        pp = '0;
      endcase
      prod = prod + (pp <<< (2 * i));
    end
  end

endmodule

module booth_mac_accum #(
  parameter int W     = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_x,
  input  logic [W-1:0]     in_y,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic             out_ovf
);

  logic                    en;
  logic                    take;

  logic signed [W-1:0]     s1_x;
  logic signed [W-1:0]     s1_y;
  logic                    s1_last;
  logic                    s1_v;

  logic signed [2*W-1:0]   prod;
  logic signed [2*W-1:0]   s2_p;
  logic                    s2_last;
  logic                    s2_v;

  logic signed [ACC_W-1:0] acc;
  logic                    ovf;
  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic                    ovf_now;

  // A held result stalls every stage at once, so nothing in flight moves or drops.
  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;
  assign take     = in_valid && in_ready;

  booth_mul #(.W(W)) u_mul (
    .x    (s1_x),
    .y    (s1_y),
    .prod (prod)
  );

  always_comb begin
    ext     = ACC_W'(s2_p);
    sum     = acc + ext;
    ovf_now = (acc[ACC_W-1] == ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
  end

  // NOTE: payload registers carry no reset; their valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (en) begin
      if (take) begin
        s1_x    <= signed'(in_x);
        s1_y    <= signed'(in_y);
        s1_last <= in_last;
      end
      s2_p    <= prod;
      s2_last <= s1_last;
    end
  end

  // NOTE: non-blocking assignments so every stage samples the pre-edge value of its source.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_acc   <= '0;
      out_ovf   <= 1'b0;
    end else if (en) begin
      s1_v <= take;
      s2_v <= s1_v;
      if (s2_v) begin
        if (s2_last) begin
          out_acc <= sum;
          out_ovf <= ovf | ovf_now;
          acc     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc <= sum;
          ovf <= ovf | ovf_now;
        end
      end
      // A fresh result on the consume edge replaces the old one without a bubble.
      if (s2_v && s2_last) begin
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_booth_mac_accum.sv
// Directed bench for booth_mac_accum: single-term vector table plus hand-written
// sequences for dot product, backpressure, overflow, reset mid-group and bubbles.

module tb_booth_mac_accum;

  localparam int W     = 16;
  localparam int ACC_W = 40;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_x;
  logic [W-1:0]     in_y;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_acc;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic signed [W-1:0]     x;
    logic signed [W-1:0]     y;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;
    string                   name;
  } vec_t;

  vec_t vecs[8];

  booth_mac_accum #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, $signed(act), act,
               $signed(exp), exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one pair and hold it until it transfers.
  task automatic send(input logic signed [W-1:0] x, input logic signed [W-1:0] y,
                      input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    in_last  = last;
    while (!in_ready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("send_timeout", 64'(n), 64'(0));
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Wait (bounded) for a result, compare it, then move past its consume edge.
  task automatic wait_result(input string name, input logic signed [ACC_W-1:0] exp_acc,
                             input logic exp_ovf);
    int n = 0;
    while (!out_valid && n < 2000) begin
      step();
      n++;
    end
    if (!out_valid) begin
      check({name, "_timeout"}, 64'(0), 64'(1));
    end else begin
      check({name, "_acc"}, 64'(signed'(out_acc)), 64'(exp_acc));
      check({name, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
      step();
    end
  endtask

  initial begin
    int n;

    vecs[0] = '{x: -16'sd32768, y: -16'sd32768, acc: 40'sd1073741824,  ovf: 1'b0, name: "min_min"};
    vecs[1] = '{x: -16'sd32768, y: 16'sd32767,  acc: -40'sd1073709056, ovf: 1'b0, name: "min_max"};
    vecs[2] = '{x: -16'sd1,     y: 16'sd1,      acc: -40'sd1,          ovf: 1'b0, name: "neg1_1"};
    vecs[3] = '{x: 16'sd32767,  y: 16'sd32767,  acc: 40'sd1073676289,  ovf: 1'b0, name: "max_max"};
    vecs[4] = '{x: 16'sd0,      y: 16'sd12345,  acc: 40'sd0,           ovf: 1'b0, name: "zero_x"};
    vecs[5] = '{x: -16'sd7,     y: 16'sd3,      acc: -40'sd21,         ovf: 1'b0, name: "neg7_3"};
    vecs[6] = '{x: 16'sd123,    y: -16'sd45,    acc: -40'sd5535,       ovf: 1'b0, name: "123_neg45"};
    vecs[7] = '{x: 16'sd1000,   y: -16'sd21846, acc: -40'sd21846000,   ovf: 1'b0, name: "alt_bits"};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_y      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_acc", 64'(out_acc), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Dot product with exact latency and one-cycle result.
    send(16'sd1, 16'sd5, 1'b0);
    send(16'sd2, 16'sd6, 1'b0);
    send(16'sd3, 16'sd7, 1'b0);
    send(16'sd4, 16'sd8, 1'b1);
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("dot_latency", 64'(n), 64'(3));
    check("dot_acc", 64'(signed'(out_acc)), 64'(70));
    check("dot_ovf", 64'(out_ovf), 64'(0));
    step();
    check("dot_one_cycle", 64'(out_valid), 64'(0));

    // Single-term table.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].x, vecs[i].y, 1'b1);
      wait_result(vecs[i].name, vecs[i].acc, vecs[i].ovf);
    end

    // Backpressure: results held stable and delivered in order after release.
    out_ready = 1'b0;
    send(16'sd3, 16'sd4, 1'b1);
    send(16'sd5, 16'sd6, 1'b1);
    send(16'sd7, 16'sd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'(0));
      check("bp_out_valid", 64'(out_valid), 64'(1));
      check("bp_acc_stable", 64'(signed'(out_acc)), 64'(12));
      step();
    end
    out_ready = 1'b1;
    wait_result("bp_r0", 40'sd12, 1'b0);
    check("bp_no_bubble1", 64'(out_valid), 64'(1));
    wait_result("bp_r1", 40'sd30, 1'b0);
    check("bp_no_bubble2", 64'(out_valid), 64'(1));
    wait_result("bp_r2", 40'sd56, 1'b0);
    check("bp_drained", 64'(out_valid), 64'(0));

    // Overflow across a long group, then a clean group.
    for (int i = 0; i < 513; i++) begin
      send(16'sd32767, 16'sd32767, i == 512);
    end
    wait_result("ovf_group", -40'sd548715691519, 1'b1);
    send(16'sd2, 16'sd3, 1'b1);
    wait_result("after_ovf", 40'sd6, 1'b0);

    // Reset mid-group discards partial work.
    send(16'sd100, 16'sd100, 1'b0);
    send(16'sd100, 16'sd100, 1'b0);
    send(16'sd100, 16'sd100, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    send(16'sd2, 16'sd3, 1'b1);
    check("midrst_no_early", 64'(out_valid), 64'(0));
    wait_result("midrst", 40'sd6, 1'b0);

    // Bubbles leave the accumulator untouched.
    send(16'sd1, 16'sd5, 1'b0);
    for (int i = 0; i < 4; i++) step();
    send(16'sd2, 16'sd6, 1'b0);
    step();
    send(16'sd3, 16'sd7, 1'b1);
    wait_result("bubbles", 40'sd38, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mac_accum.md
# booth_mac_accum

Pipelined signed multiply-accumulate stage that sits directly downstream of the radix-4 Booth multiplier in the SIMD datapath. It accepts a stream of operand pairs over a valid/ready handshake, registers each pair, and feeds it into a combinational Booth multiplier instance. It sign-extends and accumulates the registered products into a wide accumulator, and emits one dot-product result per `in_last`-terminated group. A sticky overflow flag reports any signed wrap within a group.

## Interface
- `W`, 16, operand width; signed two's complement; even.
- `ACC_W`, 40, accumulator/result width; must be ≥ 2*W.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  block can accept; a transfer occurs when `in_valid && in_ready` is high at a rising edge.
- `in_x`  in  W  signed multiplicand.
- `in_y`  in  W  signed multiplier (Booth-recoded operand).
- `in_last`  in  1  this pair is the final term of the current dot product.
- `out_valid`  out  1  result held on `out_acc`/`out_ovf`.
- `out_ready`  in  1  consumer accepts the result.
- `out_acc`  out  ACC_W  signed dot-product sum (wrapping).
- `out_ovf`  out  1  at least one signed overflow occurred while accumulating this group.

## Operation
- Global advance enable: `en = !(out_valid && !out_ready)`. `in_ready = en` (combinational). Every pipeline register updates only when `en` is high.
- S1, operand register: on transfer, latch x, y, last and set `s1_v`. With `en` high and no transfer, clear `s1_v`.
- Multiply: the S1 registers drive the combinational Booth multiplier (W×W → 2W, signed, exact).
- S2, product register: `s2_p <= prod`, `s2_v <= s1_v`, `s2_last <= s1_last`.
- S3, accumulate. The product is sign-extended from 2W to ACC_W, and `sum = acc + sext(s2_p)` is computed modulo 2^ACC_W. Signed overflow occurs when both addends have the same sign and `sum` has the opposite sign. When `s2_v` is high:
  - If `s2_last` is low: `acc <= sum` and `ovf <= ovf | ovf_now`.
  - If `s2_last` is high: `out_acc <= sum`, `out_ovf <= ovf | ovf_now`, `out_valid <= 1`, `acc <= 0`, `ovf <= 0`.
- `out_valid` clears on `out_valid && out_ready` unless a new result loads on the same edge. In that case the new result replaces the old one and `out_valid` stays high, giving back-to-back results with no bubble.
- Bubbles (`in_valid` low) do not alter `acc`.
- A group of one term (`in_last` on the first pair) yields `out_acc` equal to the product.
- No internal term counter is kept; group length is unbounded and wrap is reported through `out_ovf` only.

## Timing
- Reset values: `s1_v = s2_v = 0`, `acc = 0`, `ovf = 0`, `out_valid = 0`, `out_acc = 0`, `out_ovf = 0`. `in_ready` is 1 in the first cycle after reset.
- Latency: a pair transferred at edge k with last set gives `out_valid` high after edge k+2, i.e. 3 cycles from the accept cycle to the result cycle.
- Throughput: one pair per cycle while `out_ready` is high or no result is pending.
- Backpressure: while `out_valid && !out_ready`, the whole pipeline freezes. `in_ready` is 0, and `out_acc`/`out_ovf` must remain stable. No in-flight term is lost or duplicated.
- Reset mid-group: a synchronous `rst` discards all in-flight terms, the partial sum and any pending result. Nothing from before reset appears at the output.
- The result transfers at the edge where `out_valid && out_ready` are both high.

## Test plan
- Dot product: pairs (1,5), (2,6), (3,7), (4,8), last set on the 4th, `out_ready` held at 1.
  - Required: `out_acc = 70`, `out_ovf = 0`, `out_valid` high exactly 3 cycles after the 4th accept, for 1 cycle.
- Extremes, single-term groups:
  - (-32768,-32768) → 1073741824.
  - (-32768,32767) → -1073709056.
  - (-1,1) → -1 (sign-extended to all ones over 40 bits).
  - All with `out_ovf = 0`.
- Backpressure: stream single-term groups (3,4), (5,6), (7,8) with `out_ready = 0` for 5 cycles.
  - Required: `in_ready` drops, `out_acc = 12` stays stable.
  - After release, results 12, 30, 56 arrive in order with no loss.
- Overflow: 513 terms of (32767,32767), last on the 513th.
  - Required: `out_acc = -548715691519` (wrapped), `out_ovf = 1`.
  - A following single-term group (2,3) gives 6 with `out_ovf = 0`.
- Reset mid-group: accept (100,100) three times without last, pulse `rst` for one cycle, then send (2,3) with last.
  - Required: `out_acc = 6`, and no output appears before it.
- Bubbles: (1,5), idle for 4 cycles, (2,6), idle for 1 cycle, (3,7) with last.
  - Required: `out_acc = 38`.
